// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end with stall, redirect and optional JAL prediction
//
// Holds the fetch PC, reads the instruction array at pc_f and registers the
// fetched word plus its PC into the EX slot.
// Optional feature macro: FETCH_JAL_PREDICT_EN (fetch follows JAL targets itself).
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   inst_ram[DEPTH]     instruction array, read combinationally at pc_f
//   stall               hold PC and EX slot this cycle
//   redirect/_pc        control transfer from EX (word index); flushes EX
//   pc_f                current fetch PC (word index)
//   instruction_EX      instruction in the EX slot
//   pc_EX               word-index PC of instruction_EX
//   valid_EX            EX slot holds a real instruction (0 = bubble)
//   predicted_EX        EX instruction is a JAL that fetch already followed
//   fetch_count         valid instructions accepted into EX (wraps at 2^32)

module fetch_stage #(
  parameter int          DEPTH    = 4096,
  parameter int          RESET_PC = 0,
  parameter logic [31:0] NOP_WORD = 32'h00000013,
  localparam int         PC_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_ram [DEPTH],
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc_f,
  output logic [31:0]      instruction_EX,
  output logic [PC_W-1:0]  pc_EX,
  output logic             valid_EX,
  output logic             predicted_EX,
  output logic [31:0]      fetch_count
);

  logic [31:0]     fetch_word;
  logic [PC_W-1:0] pc_seq;
  logic            is_jal;
  logic [PC_W-1:0] jal_pc;

  assign fetch_word = inst_ram[pc_f];
  // PC_W-bit add wraps DEPTH-1 to 0 for free since DEPTH is a power of two.
  assign pc_seq     = pc_f + PC_W'(1);

`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] j_imm;

  // J-type immediate, byte offset, sign-extended to 32 bits so the word
  // offset slice stays correct for any PC_W up to 30.
  assign j_imm  = {{11{fetch_word[31]}}, fetch_word[31], fetch_word[19:12],
                   fetch_word[20], fetch_word[30:21], 1'b0};
  assign is_jal = (fetch_word[6:0] == 7'b1101111);
  assign jal_pc = pc_f + PC_W'(j_imm >> 2);
`else
  assign is_jal = 1'b0;
  assign jal_pc = pc_seq;
  assign predicted_EX = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f           <= PC_W'(RESET_PC);
      instruction_EX <= NOP_WORD;
      pc_EX          <= '0;
      valid_EX       <= 1'b0;
      fetch_count    <= '0;
`ifdef FETCH_JAL_PREDICT_EN
      predicted_EX   <= 1'b0;
`endif
    end else if (redirect) begin
      // Redirect beats stall: the EX slot becomes a bubble and pc_EX is
      // left as is since a bubble carries no meaningful PC.
      pc_f           <= redirect_pc;
      instruction_EX <= NOP_WORD;
      valid_EX       <= 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
      predicted_EX   <= 1'b0;
`endif
    end else if (!stall) begin
      pc_f           <= is_jal ? jal_pc : pc_seq;
      instruction_EX <= fetch_word;
      pc_EX          <= pc_f;
      valid_EX       <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
`ifdef FETCH_JAL_PREDICT_EN
      predicted_EX   <= is_jal;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int DEPTH = 64;
  localparam int PC_W  = 6;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JAL_P32 = 32'h0200006F; // jal x0, +32 bytes
`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     ram [DEPTH];
  logic            stall, redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] pc_f, pc_EX;
  logic [31:0]     instruction_EX, fetch_count;
  logic            valid_EX, predicted_EX;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(0), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .inst_ram(ram), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc_f(pc_f),
    .instruction_EX(instruction_EX), .pc_EX(pc_EX), .valid_EX(valid_EX),
    .predicted_EX(predicted_EX), .fetch_count(fetch_count)
  );

  typedef struct packed {
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] rpc;
    logic [PC_W-1:0] e_pc_f;
    logic [PC_W-1:0] e_pc_ex;
    logic            e_valid;
    logic [31:0]     e_count;
  } vec_t;

  typedef struct packed {
    logic [PC_W-1:0] pc_f;
    logic [PC_W-1:0] pc_ex;
    logic            valid;
    logic [31:0]     inst;
    logic [31:0]     count;
  } exp_t;

  vec_t vecs [21];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA000_0000 | (32'(i) << 8) | 32'(i);
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // stall, redirect, rpc, pc_f, pc_EX, valid, count (after the edge)
    vecs[0]  = '{1'b0, 1'b0, 6'd0,  6'd1,  6'd0,  1'b1, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 6'd0,  6'd2,  6'd1,  1'b1, 32'd2};
    vecs[2]  = '{1'b0, 1'b0, 6'd0,  6'd3,  6'd2,  1'b1, 32'd3};
    vecs[3]  = '{1'b0, 1'b0, 6'd0,  6'd4,  6'd3,  1'b1, 32'd4};
    vecs[4]  = '{1'b0, 1'b0, 6'd0,  6'd5,  6'd4,  1'b1, 32'd5};
    vecs[5]  = '{1'b0, 1'b0, 6'd0,  6'd6,  6'd5,  1'b1, 32'd6};
    vecs[6]  = '{1'b1, 1'b0, 6'd0,  6'd6,  6'd5,  1'b1, 32'd6};
    vecs[7]  = '{1'b1, 1'b0, 6'd0,  6'd6,  6'd5,  1'b1, 32'd6};
    vecs[8]  = '{1'b1, 1'b0, 6'd0,  6'd6,  6'd5,  1'b1, 32'd6};
    vecs[9]  = '{1'b0, 1'b0, 6'd0,  6'd7,  6'd6,  1'b1, 32'd7};
    vecs[10] = '{1'b0, 1'b0, 6'd0,  6'd8,  6'd7,  1'b1, 32'd8};
    vecs[11] = '{1'b0, 1'b0, 6'd0,  6'd9,  6'd8,  1'b1, 32'd9};
    vecs[12] = '{1'b0, 1'b0, 6'd0,  6'd10, 6'd9,  1'b1, 32'd10};
    vecs[13] = '{1'b0, 1'b1, 6'd40, 6'd40, 6'd0,  1'b0, 32'd10};
    vecs[14] = '{1'b0, 1'b0, 6'd0,  6'd41, 6'd40, 1'b1, 32'd11};
    vecs[15] = '{1'b1, 1'b1, 6'd7,  6'd7,  6'd0,  1'b0, 32'd11};
    vecs[16] = '{1'b0, 1'b0, 6'd0,  6'd8,  6'd7,  1'b1, 32'd12};
    vecs[17] = '{1'b0, 1'b1, 6'd62, 6'd62, 6'd0,  1'b0, 32'd12};
    vecs[18] = '{1'b0, 1'b0, 6'd0,  6'd63, 6'd62, 1'b1, 32'd13};
    vecs[19] = '{1'b0, 1'b0, 6'd0,  6'd0,  6'd63, 1'b1, 32'd14};
    vecs[20] = '{1'b0, 1'b0, 6'd0,  6'd1,  6'd0,  1'b1, 32'd15};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc_f", 32'(pc_f), 32'd0);
    chk("rst_inst", instruction_EX, NOP);
    chk("rst_pc_ex", 32'(pc_EX), 32'd0);
    chk("rst_valid", 32'(valid_EX), 32'd0);
    chk("rst_pred", 32'(predicted_EX), 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    rst_n = 1'b1;

    // Table-driven run through the scoreboard
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      e.pc_f  = vecs[i].e_pc_f;
      e.pc_ex = vecs[i].e_pc_ex;
      e.valid = vecs[i].e_valid;
      e.inst  = vecs[i].e_valid ? ram[vecs[i].e_pc_ex] : NOP;
      e.count = vecs[i].e_count;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_pc_f", i), 32'(pc_f), 32'(e.pc_f));
        chk($sformatf("v%0d_valid", i), 32'(valid_EX), 32'(e.valid));
        chk($sformatf("v%0d_inst", i), instruction_EX, e.inst);
        chk($sformatf("v%0d_count", i), fetch_count, e.count);
        chk($sformatf("v%0d_pred", i), 32'(predicted_EX), 32'd0);
        if (e.valid) chk($sformatf("v%0d_pc_ex", i), 32'(pc_EX), 32'(e.pc_ex));
      end
    end
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;

    // Mid-operation reset takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_pc_f", 32'(pc_f), 32'd0);
    chk("async_valid", 32'(valid_EX), 32'd0);
    chk("async_count", fetch_count, 32'd0);
    chk("async_inst", instruction_EX, NOP);

    // JAL at word 3: followed by fetch only when prediction is built in
    ram[3] = JAL_P32;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("jal_pc_f_at", 32'(pc_f), 32'd3);
    @(posedge clk);
    #1;
    chk("jal_pc_ex", 32'(pc_EX), 32'd3);
    chk("jal_inst", instruction_EX, JAL_P32);
    chk("jal_pred", 32'(predicted_EX), 32'(PRED));
    chk("jal_pc_f", 32'(pc_f), PRED ? 32'd11 : 32'd4);
    @(posedge clk);
    #1;
    chk("jal_next_pc_ex", 32'(pc_EX), PRED ? 32'd11 : 32'd4);
    chk("jal_next_pred", 32'(predicted_EX), 32'd0);
    chk("jal_next_valid", 32'(valid_EX), 32'd1);
    chk("jal_count", fetch_count, 32'd5);

    // Reset mid-run discards an in-flight prediction
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_pred", 32'(predicted_EX), 32'd0);
    chk("rst2_pc_f", 32'(pc_f), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch front end for the pipelined RISC-V core; it replaces the fixed 12-bit, always-increment fetch logic in the CPU top. It holds the PC, reads the instruction array, and registers the instruction and its PC into the EX pipeline register. On top of plain sequential fetch it adds a pipeline stall, redirect/flush from EX for branches and jumps, a valid bit per EX slot, and a fetched-instruction counter. It sits between the instruction RAM array and the EX-stage decoder/control logic.

## Interface
- DEPTH, 4096, instruction array depth in 32-bit words; power of two, ≥2; localparam PC_W = $clog2(DEPTH).
- RESET_PC, 0, word index loaded into the PC at reset; must be < DEPTH.
- NOP_WORD, 32'h00000013, bubble instruction (addi x0,x0,0) placed in EX on reset and flush.
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst_ram  input  32 x DEPTH  instruction array; read combinationally at pc_f.
- stall  input  1  hold fetch and the EX register this cycle.
- redirect  input  1  EX requests a control transfer; the EX slot is flushed.
- redirect_pc  input  PC_W  word-index target for redirect.
- pc_f  output  PC_W  current fetch PC (word index).
- instruction_EX  output  32  instruction presented to decode.
- pc_EX  output  PC_W  word-index PC of instruction_EX.
- valid_EX  output  1  instruction_EX is real; 0 means bubble, so EX must suppress regwrite and gpio_we.
- predicted_EX  output  1  instruction_EX is a JAL already followed by fetch.
- fetch_count  output  32  number of valid instructions accepted into EX.

## Operation
- Reset values (asynchronous on rst_n low):
  - pc_f = RESET_PC
  - instruction_EX = NOP_WORD
  - pc_EX = 0
  - valid_EX = 0
  - predicted_EX = 0
  - fetch_count = 0
- Update priority each edge: redirect > stall > (predicted jump) > sequential.
- Redirect:
  - pc_f ← redirect_pc
  - instruction_EX ← NOP_WORD, valid_EX ← 0, predicted_EX ← 0
  - fetch_count does not change
  - redirect overrides a simultaneous stall.
- Stall (no redirect): pc_f, instruction_EX, pc_EX, valid_EX, predicted_EX and fetch_count all hold.
- Sequential fetch:
  - pc_f ← pc_f + 1, modulo DEPTH; DEPTH-1 wraps to 0.
  - instruction_EX ← inst_ram[pc_f], pc_EX ← pc_f, valid_EX ← 1
  - fetch_count ← fetch_count + 1, wrapping at 2^32.
- Width rules:
  - Instructions are word-indexed; redirect_pc is a word index, not a byte address.
  - Targets are truncated to PC_W bits, so all PC arithmetic is modulo DEPTH.

## Timing
- Fetch-to-EX latency is 1 cycle. The word at pc_f in cycle n appears on instruction_EX in cycle n+1.
- Redirect asserted in cycle n:
  - cycle n+1 has a bubble in EX and pc_f = target
  - cycle n+2 has the target instruction in EX
  - branch penalty is 1 bubble.
- redirect and stall are sampled only at the rising edge; there are no combinational paths from them to any output.
- Leaving reset: the first valid instruction (inst_ram[RESET_PC]) is in EX on the 1st edge after rst_n is released.
- Reset asserted mid-operation takes effect immediately; an in-flight redirect or prediction is discarded.

## Configuration
- FETCH_JAL_PREDICT_EN defined:
  - Applies when neither redirect nor stall is active and inst_ram[pc_f][6:0] == 7'b1101111.
  - pc_f ← pc_f + sext(J-imm)[PC_W+1:2], modulo DEPTH.
  - The JAL itself still enters EX with valid_EX = 1 and predicted_EX = 1; EX must not redirect for it.
  - Zero-bubble jumps.
- FETCH_JAL_PREDICT_EN undefined:
  - No opcode inspection in fetch; predicted_EX is tied to 0.
  - JAL is resolved by an EX redirect (1 bubble).

## Test plan
- Reset: hold rst_n=0, then release with RESET_PC=0 -> during reset pc_f=0, instruction_EX=0x00000013, valid_EX=0; after the 1st edge instruction_EX=inst_ram[0], pc_EX=0, valid_EX=1, fetch_count=1.
- Wrap: DEPTH=16, free-run 17 cycles -> pc_f goes 15→0, pc_EX sequence …14,15,0, fetch_count=17.
- Stall: assert stall for 3 cycles while instruction_EX=inst_ram[5] -> pc_f=6, pc_EX=5 and fetch_count are unchanged for 3 cycles; pc_EX=6 on the edge after stall drops.
- Redirect: redirect=1, redirect_pc=40 at pc_f=10 -> next cycle valid_EX=0, instruction_EX=NOP, pc_f=40, fetch_count unchanged; the following cycle pc_EX=40, valid_EX=1.
- Simultaneous events: stall=1 and redirect=1 together, redirect_pc=7 -> redirect wins; pc_f=7 and a bubble in EX.
- Prediction, with the macro defined: inst_ram[3]=JAL x0,+32 bytes -> EX pc_EX=3, predicted_EX=1, and the next pc_EX=11. With the macro undefined: pc_EX=4 follows and predicted_EX stays 0.
